mem_router: RTL and testbench

MEM_ROUTER -- requirements
Module: mem_router

---
 rtl/mem_router_pkg.sv | 18 +
 rtl/mem_router_decode.sv | 32 +++
 rtl/mem_router.sv | 157 +++++++++++++++
 tb/tb_mem_router.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_router_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_router_pkg : FSM encoding and shared constants for mem_router. Rev 1.0
// ---------------------------------------------------------------------------
package mem_router_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int         WAIT_W        = 4;
  localparam logic [7:0] OPEN_BUS_DFLT = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/mem_router_decode.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_router_decode : combinational region priority decoder. Rev 1.0
// ---------------------------------------------------------------------------
module mem_router_decode
  import mem_router_pkg::*;
#(
  parameter int                        ADDR_W      = 20,
  parameter int                        REGIONS     = 3,
  parameter int                        IDX_W       = 2,
  parameter logic [REGIONS*ADDR_W-1:0] REGION_BASE = '0,
  parameter logic [REGIONS*ADDR_W-1:0] REGION_MASK = '0
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic              hit_o,
  output logic [IDX_W-1:0]  idx_o
);

  // Scan from the highest index down so the lowest matching index overrides.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int i = REGIONS - 1; i >= 0; i--) begin
      if ((addr_i & REGION_MASK[i*ADDR_W +: ADDR_W]) == REGION_BASE[i*ADDR_W +: ADDR_W]) begin
        hit_o = 1'b1;
        idx_o = IDX_W'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_router.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_router : CPU-to-region access sequencer with wait states and fault
//              capture. Rev 1.0
// ---------------------------------------------------------------------------
module mem_router
  import mem_router_pkg::*;
#(
  parameter int                        ADDR_W      = 20,
  parameter int                        DATA_W      = 8,
  parameter int                        REGIONS     = 3,
  parameter logic [REGIONS*ADDR_W-1:0] REGION_BASE = {20'hF8000, 20'hB8000, 20'h00000},
  parameter logic [REGIONS*ADDR_W-1:0] REGION_MASK = {20'hF8000, 20'hFE000, 20'hC0000},
  parameter logic [REGIONS*WAIT_W-1:0] REGION_WAIT = {4'd1, 4'd1, 4'd1},
  parameter logic [REGIONS-1:0]        REGION_RO   = 3'b100,
  parameter logic [DATA_W-1:0]         OPEN_BUS    = DATA_W'(OPEN_BUS_DFLT)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        req,
  input  logic [ADDR_W-1:0]           address,
  input  logic [DATA_W-1:0]           o_data,
  input  logic                        we,
  output logic                        ready,
  output logic [DATA_W-1:0]           i_data,
  output logic [ADDR_W-1:0]           rgn_addr,
  output logic [DATA_W-1:0]           rgn_data,
  output logic [REGIONS-1:0]          rgn_we,
  input  logic [REGIONS*DATA_W-1:0]   rgn_q,
  input  logic                        fault_clr,
  output logic                        bus_fault,
  output logic [ADDR_W-1:0]           fault_addr
);

  localparam int IDX_W = (REGIONS > 1) ? $clog2(REGIONS) : 1;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                we_q, we_d;
  logic                hit_q, hit_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [WAIT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                fault_q, fault_d;
  logic [ADDR_W-1:0]   faddr_q, faddr_d;

  logic                dec_hit;
  logic [IDX_W-1:0]    dec_idx;
  logic [WAIT_W-1:0]   dec_wait;
  logic [DATA_W-1:0]   done_data;
  logic                fault_set;

  mem_router_decode #(
    .ADDR_W      (ADDR_W),
    .REGIONS     (REGIONS),
    .IDX_W       (IDX_W),
    .REGION_BASE (REGION_BASE),
    .REGION_MASK (REGION_MASK)
  ) u_decode (
    .addr_i (address),
    .hit_o  (dec_hit),
    .idx_o  (dec_idx)
  );

  assign dec_wait  = dec_hit ? REGION_WAIT[int'(dec_idx)*WAIT_W +: WAIT_W] : '0;
  // Writes and unmapped accesses both return the open-bus pattern.
  assign done_data = (hit_q && !we_q) ? rgn_q[int'(idx_q)*DATA_W +: DATA_W] : OPEN_BUS;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    we_d      = we_q;
    hit_d     = hit_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    fault_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          addr_d  = address;
          data_d  = o_data;
          we_d    = we;
          hit_d   = dec_hit;
          idx_d   = dec_idx;
          cnt_d   = dec_wait;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        fault_set = !hit_q || (we_q && REGION_RO[idx_q]);
        if (cnt_q == '0) begin
          state_d = ST_DONE;
          rdata_d = done_data;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - WAIT_W'(1);
        if (cnt_q == WAIT_W'(1)) begin
          state_d = ST_DONE;
          rdata_d = done_data;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    // A new fault overrides a simultaneous clear.
    fault_d = fault_set | (fault_q & ~fault_clr);
    faddr_d = (fault_set && !fault_q) ? addr_q : faddr_q;
  end

  always_comb begin
    rgn_we = '0;
    if (state_q == ST_ACCESS && hit_q && we_q && !REGION_RO[idx_q]) begin
      rgn_we[idx_q] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      hit_q   <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= OPEN_BUS;
      fault_q <= 1'b0;
      faddr_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      hit_q   <= hit_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
      faddr_q <= faddr_d;
    end
  end

  assign ready      = (state_q == ST_DONE);
  assign i_data     = rdata_q;
  assign rgn_addr   = addr_q;
  assign rgn_data   = data_q;
  assign bus_fault  = fault_q;
  assign fault_addr = faddr_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_router.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mem_router : directed self-checking bench for mem_router. Rev 1.0
// ---------------------------------------------------------------------------
module tb_mem_router;

  logic        clock = 1'b0;
  logic        reset;
  logic        req;
  logic [19:0] address;
  logic [7:0]  o_data;
  logic        we;
  logic        ready;
  logic [7:0]  i_data;
  logic [19:0] rgn_addr;
  logic [7:0]  rgn_data;
  logic [2:0]  rgn_we;
  logic [23:0] rgn_q;
  logic        fault_clr;
  logic        bus_fault;
  logic [19:0] fault_addr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  // Region 1 is given 5 wait states; regions 0 and 2 keep 1.
  mem_router #(
    .REGION_WAIT ({4'd1, 4'd5, 4'd1})
  ) u_dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .address    (address),
    .o_data     (o_data),
    .we         (we),
    .ready      (ready),
    .i_data     (i_data),
    .rgn_addr   (rgn_addr),
    .rgn_data   (rgn_data),
    .rgn_we     (rgn_we),
    .rgn_q      (rgn_q),
    .fault_clr  (fault_clr),
    .bus_fault  (bus_fault),
    .fault_addr (fault_addr)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Called one step after an edge (cycle 0); returns in cycle 1 with req low.
  task automatic issue(input logic [19:0] a, input logic [7:0] d, input logic w);
    req     = 1'b1;
    address = a;
    o_data  = d;
    we      = w;
    step();
    req     = 1'b0;
  endtask

  task automatic wait_ready(inout int cyc);
    while (ready !== 1'b1 && cyc < 30) begin
      step();
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 1'b0; address = '0; o_data = '0; we = 1'b0; fault_clr = 1'b0;
    rgn_q = {8'hC3, 8'hA5, 8'h5A};
    step(); step();
    reset = 1'b0;
    n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", ready); end
    n_tests++; if (rgn_we !== 3'b000) begin n_fail++; $display("FAIL reset_rgn_we: got %b want 000", rgn_we); end
    n_tests++; if (i_data !== 8'hFF) begin n_fail++; $display("FAIL reset_i_data: got %h want ff", i_data); end
    n_tests++; if (rgn_addr !== 20'h0) begin n_fail++; $display("FAIL reset_rgn_addr: got %h want 0", rgn_addr); end
    n_tests++; if (rgn_data !== 8'h0) begin n_fail++; $display("FAIL reset_rgn_data: got %h want 0", rgn_data); end
    n_tests++; if (bus_fault !== 1'b0) begin n_fail++; $display("FAIL reset_bus_fault: got %b want 0", bus_fault); end
    n_tests++; if (fault_addr !== 20'h0) begin n_fail++; $display("FAIL reset_fault_addr: got %h want 0", fault_addr); end
  endtask

  task automatic test_read();
    int cyc;
    issue(20'h12345, 8'h00, 1'b0);
    n_tests++; if (rgn_we !== 3'b000) begin n_fail++; $display("FAIL read_rgn_we: got %b want 000", rgn_we); end
    cyc = 1;
    wait_ready(cyc);
    n_tests++; if (cyc != 3) begin n_fail++; $display("FAIL read_latency: got %0d want 3", cyc); end
    n_tests++; if (i_data !== 8'h5A) begin n_fail++; $display("FAIL read_i_data: got %h want 5a", i_data); end
    step(); step(); step();
    n_tests++; if (i_data !== 8'h5A || ready !== 1'b0) begin
      n_fail++; $display("FAIL read_hold: got i_data=%h ready=%b want 5a/0", i_data, ready);
    end
  endtask

  task automatic test_write();
    int cyc;
    issue(20'hB8010, 8'h77, 1'b1);
    n_tests++; if (rgn_we !== 3'b010) begin n_fail++; $display("FAIL write_rgn_we: got %b want 010", rgn_we); end
    n_tests++; if (rgn_data !== 8'h77) begin n_fail++; $display("FAIL write_rgn_data: got %h want 77", rgn_data); end
    n_tests++; if (rgn_addr !== 20'hB8010) begin n_fail++; $display("FAIL write_rgn_addr: got %h want b8010", rgn_addr); end
    step();
    n_tests++; if (rgn_we !== 3'b000) begin n_fail++; $display("FAIL write_we_pulse: got %b want 000", rgn_we); end
    cyc = 2;
    wait_ready(cyc);
    n_tests++; if (cyc != 7) begin n_fail++; $display("FAIL write_latency: got %0d want 7", cyc); end
    n_tests++; if (rgn_addr !== 20'hB8010 || rgn_data !== 8'h77) begin
      n_fail++; $display("FAIL write_stable: got %h/%h want b8010/77", rgn_addr, rgn_data);
    end
    n_tests++; if (bus_fault !== 1'b0) begin n_fail++; $display("FAIL write_no_fault: got %b want 0", bus_fault); end
    step();
  endtask

  task automatic test_fault();
    int cyc;
    issue(20'hFFFF0, 8'h11, 1'b1);
    n_tests++; if (rgn_we !== 3'b000) begin n_fail++; $display("FAIL ro_rgn_we: got %b want 000", rgn_we); end
    cyc = 1;
    wait_ready(cyc);
    n_tests++; if (cyc != 3) begin n_fail++; $display("FAIL ro_latency: got %0d want 3", cyc); end
    n_tests++; if (bus_fault !== 1'b1) begin n_fail++; $display("FAIL ro_bus_fault: got %b want 1", bus_fault); end
    n_tests++; if (fault_addr !== 20'hFFFF0) begin n_fail++; $display("FAIL ro_fault_addr: got %h want ffff0", fault_addr); end
    step();
    rgn_q = {8'hC3, 8'hA5, 8'h3C};
    issue(20'h12345, 8'h00, 1'b0);
    cyc = 1;
    wait_ready(cyc);
    n_tests++; if (i_data !== 8'h3C) begin n_fail++; $display("FAIL reread_i_data: got %h want 3c", i_data); end
    step();
    issue(20'h80000, 8'h00, 1'b0);
    cyc = 1;
    wait_ready(cyc);
    n_tests++; if (cyc != 2) begin n_fail++; $display("FAIL unmapped_latency: got %0d want 2", cyc); end
    n_tests++; if (i_data !== 8'hFF) begin n_fail++; $display("FAIL unmapped_i_data: got %h want ff", i_data); end
    n_tests++; if (fault_addr !== 20'hFFFF0) begin n_fail++; $display("FAIL first_fault_kept: got %h want ffff0", fault_addr); end
    step();
  endtask

  task automatic test_fault_clr();
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    n_tests++; if (bus_fault !== 1'b0) begin n_fail++; $display("FAIL clr_only: got %b want 0", bus_fault); end
    issue(20'h40000, 8'h00, 1'b0);
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    n_tests++; if (bus_fault !== 1'b1) begin n_fail++; $display("FAIL set_beats_clr: got %b want 1", bus_fault); end
    n_tests++; if (fault_addr !== 20'h40000) begin n_fail++; $display("FAIL clr_new_addr: got %h want 40000", fault_addr); end
    n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL clr_ready: got %b want 1", ready); end
    step();
  endtask

  task automatic test_wait_busy();
    int cyc;
    logic bad_we;
    bad_we = 1'b0;
    issue(20'hB8000, 8'h00, 1'b0);
    cyc = 1;
    while (ready !== 1'b1 && cyc < 30) begin
      if (rgn_we !== 3'b000) bad_we = 1'b1;
      req = (cyc >= 2 && cyc <= 5);
      address = 20'h12345; we = 1'b1; o_data = 8'hEE;
      step();
      cyc++;
    end
    req = 1'b0;
    n_tests++; if (cyc != 7) begin n_fail++; $display("FAIL wait_latency: got %0d want 7", cyc); end
    n_tests++; if (i_data !== 8'hA5) begin n_fail++; $display("FAIL wait_i_data: got %h want a5", i_data); end
    n_tests++; if (rgn_addr !== 20'hB8000) begin n_fail++; $display("FAIL busy_addr: got %h want b8000", rgn_addr); end
    n_tests++; if (bad_we !== 1'b0) begin n_fail++; $display("FAIL busy_rgn_we: got %b want 0", bad_we); end
    cyc = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (ready === 1'b1 || rgn_we !== 3'b000) cyc++;
    end
    n_tests++; if (cyc != 0) begin n_fail++; $display("FAIL busy_ignored: got %0d extra strobes want 0", cyc); end
  endtask

  task automatic test_back_to_back();
    int first, second, pulses;
    first = 0; second = 0; pulses = 0;
    rgn_q = {8'hC3, 8'hA5, 8'h5A};
    req = 1'b1; address = 20'h12345; we = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (c == 12) req = 1'b0;
      if (ready === 1'b1) begin
        pulses++;
        if (pulses == 1) first = c;
        if (pulses == 2) second = c;
      end
    end
    n_tests++; if (first != 3) begin n_fail++; $display("FAIL b2b_first: got %0d want 3", first); end
    n_tests++; if (second != 7) begin n_fail++; $display("FAIL b2b_second: got %0d want 7", second); end
    n_tests++; if (pulses != 3) begin n_fail++; $display("FAIL b2b_count: got %0d want 3", pulses); end
    step(); step();
  endtask

  task automatic test_reset_mid();
    int cnt;
    int cyc;
    issue(20'hB8000, 8'h00, 1'b0);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL mid_ready: got %b want 0", ready); end
    n_tests++; if (i_data !== 8'hFF) begin n_fail++; $display("FAIL mid_i_data: got %h want ff", i_data); end
    n_tests++; if (rgn_addr !== 20'h0 || bus_fault !== 1'b0 || fault_addr !== 20'h0) begin
      n_fail++; $display("FAIL mid_regs: got %h/%b/%h want 0/0/0", rgn_addr, bus_fault, fault_addr);
    end
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (ready === 1'b1 || rgn_we !== 3'b000) cnt++;
      step();
    end
    n_tests++; if (cnt != 0) begin n_fail++; $display("FAIL mid_no_strobe: got %0d want 0", cnt); end
    issue(20'h12345, 8'h00, 1'b0);
    cyc = 1;
    wait_ready(cyc);
    n_tests++; if (cyc != 3 || i_data !== 8'h5A) begin
      n_fail++; $display("FAIL post_reset_read: got %0d/%h want 3/5a", cyc, i_data);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_fault();
    test_fault_clr();
    test_wait_busy();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
